// File: rtl/sar_dac_sequencer.sv
// SAR sequencer for the capacitive DAC path: sample phase, per-bit settle and
// compare timing, trial-code generation and the start/busy/done handshake.
// Ports: clk, rst (async, active-high) | start, comp_in, test_en, test_code in
//        sample, dac_trial (mux A), dac_sel (0=A, 1=test_code), result, busy, done out
module sar_dac_sequencer #(
  parameter int N_BITS        = 10,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              comp_in,
  input  logic              test_en,
  input  logic [N_BITS-1:0] test_code,
  output logic              sample,
  output logic [N_BITS-1:0] dac_trial,
  output logic              dac_sel,
  output logic [N_BITS-1:0] result,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SAMPLE = 2'd1;
  localparam logic [1:0] S_BIT    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int IW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [IW-1:0] IDX_TOP   = IW'(N_BITS - 1);
  localparam logic [3:0]    SAMP_LAST = 4'(SAMPLE_CYCLES - 1);
  localparam logic [3:0]    SETL_LAST = 4'(SETTLE_CYCLES);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [N_BITS-1:0] trial_q, trial_d;
  logic [N_BITS-1:0] result_q, result_d;
  logic              sample_q, busy_q, done_q;

  // test_code only feeds the external mux; kept as a port for visibility.
  logic unused_test_code;
  assign unused_test_code = ^test_code;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    trial_d  = trial_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SAMPLE;
          cnt_d   = '0;
          trial_d = '0;
        end
      end
      S_SAMPLE: begin
        if (cnt_q == SAMP_LAST) begin
          state_d             = S_BIT;
          cnt_d               = '0;
          idx_d               = IDX_TOP;
          trial_d[N_BITS-1]   = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_BIT: begin
        if (cnt_q == SETL_LAST) begin
          // Decision edge: resolve this bit, then raise the next trial bit.
          trial_d[idx_q] = comp_in;
          cnt_d          = '0;
          if (idx_q != '0) begin
            trial_d[idx_q - IW'(1)] = 1'b1;
            idx_d                   = idx_q - IW'(1);
          end else begin
            state_d  = S_DONE;
            result_d = trial_d;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        trial_d = '0;
        idx_d   = IDX_TOP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so the S/H switch
  // and handshake see clean, glitch-free levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= IDX_TOP;
      trial_q  <= '0;
      result_q <= '0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      sample_q <= (state_d == S_SAMPLE);
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign sample    = sample_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dac_trial = trial_q;
  assign result    = result_q;
  assign dac_sel   = test_en & (state_q == S_IDLE);

endmodule

// File: tb/tb_sar_dac_sequencer.sv
// Directed bench for sar_dac_sequencer: default instance plus a fast
// instance (SAMPLE_CYCLES=1, SETTLE_CYCLES=0) sharing clock and reset.
module tb_sar_dac_sequencer;

  logic       clk;
  logic       rst;
  logic       start, test_en, comp_in;
  logic [9:0] test_code, vin;
  logic       sample, dac_sel, busy, done;
  logic [9:0] dac_trial, result;

  logic       start2, comp2, test_en2;
  logic [9:0] vin2, test_code2;
  logic       sample2, dac_sel2, busy2, done2;
  logic [9:0] dac_trial2, result2;

  int n_chk  = 0;
  int n_pass = 0;

  assign comp_in = (vin >= dac_trial);
  assign comp2   = (vin2 >= dac_trial2);

  sar_dac_sequencer u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .comp_in   (comp_in),
    .test_en   (test_en),
    .test_code (test_code),
    .sample    (sample),
    .dac_trial (dac_trial),
    .dac_sel   (dac_sel),
    .result    (result),
    .busy      (busy),
    .done      (done)
  );

  sar_dac_sequencer #(
    .N_BITS        (10),
    .SAMPLE_CYCLES (1),
    .SETTLE_CYCLES (0)
  ) u_fast (
    .clk       (clk),
    .rst       (rst),
    .start     (start2),
    .comp_in   (comp2),
    .test_en   (test_en2),
    .test_code (test_code2),
    .sample    (sample2),
    .dac_trial (dac_trial2),
    .dac_sel   (dac_sel2),
    .result    (result2),
    .busy      (busy2),
    .done      (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic pulse_at(input bit en, input int k);
    return en && (k == 5 || k == 23);
  endfunction

  // One conversion on the default instance; k counts edges after E0.
  task automatic run_conv(input logic [9:0] v,
                          input logic [9:0] exp_res,
                          input bit pulses);
    int k;
    int sc;
    logic [9:0] code;
    logic [9:0] tr;
    vin   = v;
    start = 1'b1;
    tick;
    start = 1'b0;
    k     = 0;
    chk("busy_rise", busy, 1);
    chk("sel_conv", dac_sel, 0);
    sc = 0;
    while (sample && sc < 20) begin
      sc++;
      start = pulse_at(pulses, k + 1);
      tick;
      k++;
    end
    chk("sample_len", sc, 4);
    code = '0;
    for (int b = 9; b >= 0; b--) begin
      tr = code | (10'd1 << b);
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("trial_b%0d_c%0d", b, c), dac_trial, tr);
        chk("no_early_done", done, 0);
        if (c == 0) chk("sel_bit", dac_sel, 0);
        start = pulse_at(pulses, k + 1);
        tick;
        k++;
      end
      if (v >= tr) code = tr;
    end
    start = 1'b0;
    chk("done_lat", k, 24);
    chk("done_hi", done, 1);
    chk("busy_done", busy, 1);
    chk("result", result, exp_res);
    tick;
    chk("done_1cyc", done, 0);
    chk("busy_fall", busy, 0);
    chk("trial_clr", dac_trial, 0);
    chk("result_hold", result, exp_res);
    chk("sel_idle", dac_sel, test_en);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("no_requeue", busy, 0);
    end
  endtask

  initial begin
    int k;
    int d1;
    rst        = 1'b1;
    start      = 1'b0;
    test_en    = 1'b0;
    test_code  = '0;
    vin        = '0;
    start2     = 1'b0;
    test_en2   = 1'b0;
    test_code2 = '0;
    vin2       = '0;
    repeat (3) tick;
    chk("rst_sample", sample, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_trial", dac_trial, 0);
    chk("rst_result", result, 0);
    chk("rst_sel", dac_sel, 0);
    #2 rst = 1'b0;
    tick;

    test_en   = 1'b1;
    test_code = 10'h2AA;
    #1;
    chk("sel_test", dac_sel, 1);
    run_conv(10'd613, 10'd613, 1'b1);
    test_en = 1'b0;
    run_conv(10'd0, 10'd0, 1'b0);
    run_conv(10'd1023, 10'd1023, 1'b0);

    // Start held high: back-to-back conversions every 26 cycles.
    vin   = 10'd613;
    start = 1'b1;
    tick;
    k = 0;
    while (!done && k < 100) begin tick; k++; end
    chk("b2b_first", k, 24);
    chk("b2b_res1", result, 613);
    d1 = k;
    tick;
    k++;
    chk("b2b_1cyc", done, 0);
    while (!done && k < 100) begin tick; k++; end
    chk("b2b_period", k - d1, 26);
    chk("b2b_res2", result, 613);
    start = 1'b0;
    while (busy && k < 200) begin tick; k++; end
    chk("b2b_stop", busy, 0);

    // Asynchronous reset mid-BIT.
    vin   = 10'd613;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (10) tick;
    chk("pre_rst_busy", busy, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_sample", sample, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_trial", dac_trial, 0);
    chk("arst_result", result, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("arst_no_done", done, 0);
    end
    #2 rst = 1'b0;
    tick;
    chk("post_rst_result", result, 0);
    run_conv(10'd613, 10'd613, 1'b0);

    // Fast parameter set.
    vin2   = 10'd300;
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    chk("fast_sample", sample2, 1);
    chk("fast_sel", dac_sel2, 0);
    k = 0;
    while (!done2 && k < 40) begin tick; k++; end
    chk("fast_lat", k, 11);
    chk("fast_result", result2, 300);
    chk("fast_busy", busy2, 1);
    tick;
    chk("fast_idle", busy2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
